// File: rtl/mem_ctrl_param.sv
// rtl/mem_ctrl_param.sv - parametrised single-port word memory controller, fixed latency, valid/ready
// Optional byte-strobe writes: define MEMCTRL_WSTRB_EN (otherwise every write updates the full word).
module mem_ctrl_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_we,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   c_addr;
  logic                c_we;
  logic [DATA_W-1:0]   c_wdata;
  logic [STRB_W-1:0]   c_wstrb;
  logic [STRB_W-1:0]   c_be;
  logic [IDX_W-1:0]    c_idx;
  logic                c_in_range;
  logic                complete;
  logic                unused_bits;

  assign req_ready = (state == IDLE);

  // With LATENCY==1 completion happens on the accepting edge, before the latches hold the request.
  always_comb begin
    c_addr  = lat_addr;
    c_we    = lat_we;
    c_wdata = lat_wdata;
    c_wstrb = lat_wstrb;
    if (state == IDLE) begin
      c_addr  = req_addr;
      c_we    = req_we;
      c_wdata = req_wdata;
      c_wstrb = req_wstrb;
    end
  end

`ifdef MEMCTRL_WSTRB_EN
  assign c_be = c_wstrb;
`else
  assign c_be = '1;
`endif

  assign c_idx       = c_addr[ADDR_W-1:OFF_W];
  assign c_in_range  = ({1'b0, c_idx} < (IDX_W + 1)'(DEPTH));
  assign complete    = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == CNT_W'(LATENCY - 1)));
  assign unused_bits = ^{c_addr, c_wstrb};

  always_ff @(posedge clk) begin
    if (!rst && complete && c_we && c_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (c_be[b]) mem[c_idx[MEM_AW-1:0]][b*8 +: 8] <= c_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            cnt       <= CNT_W'(1);
            state     <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (complete) state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (complete) begin
        resp_valid <= 1'b1;
        resp_err   <= !c_in_range;
        resp_rdata <= (!c_we && c_in_range) ? mem[c_idx[MEM_AW-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl_param.sv
// tb/tb_mem_ctrl_param.sv - directed table-driven bench for mem_ctrl_param (LATENCY=4 and LATENCY=1)
module tb_mem_ctrl_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [23:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;

  logic        l1_req_valid, l1_req_ready, l1_req_we, l1_resp_valid, l1_resp_ready, l1_resp_err;
  logic [23:0] l1_req_addr;
  logic [31:0] l1_req_wdata, l1_resp_rdata;
  logic [3:0]  l1_req_wstrb;

  mem_ctrl_param #(.DATA_W(32), .ADDR_W(24), .DEPTH(16), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_ctrl_param #(.DATA_W(32), .ADDR_W(24), .DEPTH(16), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_addr(l1_req_addr), .req_we(l1_req_we), .req_wdata(l1_req_wdata), .req_wstrb(l1_req_wstrb),
    .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready), .resp_rdata(l1_resp_rdata),
    .resp_err(l1_resp_err)
  );

`ifdef MEMCTRL_WSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'h01BB03DD;
  localparam bit WSTRB_ON = 1'b1;
`else
  localparam logic [31:0] STRB_EXP = 32'hAABBCCDD;
  localparam bit WSTRB_ON = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [16];
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input string name, input logic we, input logic [23:0] addr,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0; req_wstrb = '0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      chk({name, " req_ready busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd4);
    chk({name, " rdata"}, resp_rdata, exp_rd);
    chk({name, " err"}, 32'(resp_err), 32'(exp_err));
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({name, " valid cleared"}, 32'(resp_valid), 32'd0);
    chk({name, " rdata cleared"}, resp_rdata, 32'd0);
  endtask

  task automatic txn_l1(input string name, input logic we, input logic [23:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    l1_req_valid = 1'b1; l1_req_we = we; l1_req_addr = addr; l1_req_wdata = wd; l1_req_wstrb = 4'hf;
    @(posedge clk); #1;
    l1_req_valid = 1'b0;
    lat = 1;
    while (!l1_resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd1);
    chk({name, " rdata"}, l1_resp_rdata, exp_rd);
    @(negedge clk);
    l1_resp_ready = 1'b1;
    @(posedge clk); #1;
    l1_resp_ready = 1'b0;
    chk({name, " valid cleared"}, 32'(l1_resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 0;
    l1_req_valid = 0; l1_req_we = 0; l1_req_addr = '0; l1_req_wdata = '0; l1_req_wstrb = '0;
    l1_resp_ready = 0;

    vecs[0]  = '{1'b1, 24'h000000, 32'h0080016f, 4'hf, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 24'h000000, 32'h0,        4'h0, 32'h0080016f, 1'b0};
    vecs[2]  = '{1'b1, 24'h00000c, 32'h01020304, 4'hf, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 24'h00000c, 32'h0,        4'h0, 32'h01020304, 1'b0};
    vecs[4]  = '{1'b1, 24'h00000c, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 24'h00000c, 32'h0,        4'h0, STRB_EXP, 1'b0};
    vecs[6]  = '{1'b0, 24'h000040, 32'h0,        4'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 24'h000040, 32'hdeadbeef, 4'hf, 32'h0, 1'b1};
    vecs[8]  = '{1'b1, 24'h00003c, 32'h11223344, 4'hf, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 24'h00003f, 32'h0,        4'h0, 32'h11223344, 1'b0};
    vecs[10] = '{1'b0, 24'h0ffffc, 32'h0,        4'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 24'h000002, 32'h0,        4'h0, 32'h0080016f, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset l1 req_ready", 32'(l1_req_ready), 32'd1);
    chk("reset l1 resp_valid", 32'(l1_resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 32'h1000_0000 + 32'(i);
      txn($sformatf("init%0d", i), 1'b1, 24'(i * 4), exp_mem[i], 4'hf, 32'h0, 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
          vecs[i].rdata, vecs[i].err);
      if (vecs[i].we && vecs[i].addr < 24'h40) begin
        for (int b = 0; b < 4; b++)
          if (vecs[i].wstrb[b] || !WSTRB_ON)
            exp_mem[vecs[i].addr[5:2]][b*8 +: 8] = vecs[i].wdata[b*8 +: 8];
      end
    end

    for (int i = 0; i < 16; i++)
      txn($sformatf("sweep%0d", i), 1'b0, 24'(i * 4), 32'h0, 4'h0, exp_mem[i], 1'b0);

    // Backpressure: response held 5 cycles while stray requests are presented.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h00000c;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp valid", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h0; req_wdata = 32'hffffffff; req_wstrb = 4'hf;
      chk($sformatf("bp valid hold%0d", i), 32'(resp_valid), 32'd1);
      chk($sformatf("bp rdata hold%0d", i), resp_rdata, exp_mem[3]);
      chk($sformatf("bp err hold%0d", i), 32'(resp_err), 32'd0);
      chk($sformatf("bp req_ready%0d", i), 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp release valid", 32'(resp_valid), 32'd0);
    chk("bp release idle", 32'(req_ready), 32'd1);
    txn("bp no side effect", 1'b0, 24'h000000, 32'h0, 4'h0, exp_mem[0], 1'b0);

    // Reset two cycles into a pending write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000008; req_wdata = 32'hcafef00d; req_wstrb = 4'hf;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) n++;
    end
    chk("midrst no resp", 32'(n), 32'd0);
    txn("midrst mem2", 1'b0, 24'h000008, 32'h0, 4'h0, exp_mem[2], 1'b0);

    // LATENCY=1 instance.
    txn_l1("l1 write", 1'b1, 24'h000004, 32'h5a5a5a5a, 32'h0);
    txn_l1("l1 read", 1'b0, 24'h000004, 32'h0, 32'h5a5a5a5a);
    @(negedge clk);
    l1_req_valid = 1'b1; l1_req_we = 1'b0; l1_req_addr = 24'h000004;
    @(posedge clk); #1;
    l1_req_valid = 1'b0;
    chk("l1 rst resp up", 32'(l1_resp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("l1 rst resp dropped", 32'(l1_resp_valid), 32'd0);
    chk("l1 rst rdata", l1_resp_rdata, 32'd0);
    chk("l1 rst req_ready", 32'(l1_req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
